program_store: RTL and testbench

//   On-chip instruction memory feeding the control/multiprocessor pair. The core presents

---
 rtl/isa_pkg.sv | 20 ++
 rtl/program_store_ram.sv | 32 +++
 rtl/program_store.sv | 139 +++++++++++++
 tb/tb_program_store.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Purpose: shared ISA types for the core and its program store.
// Contents: pc_t, instruction_t, INSTR_NOP, loader_state_t.
package isa;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instruction_t;

  // Canonical no-op (addi x0, x0, 0) returned whenever the store is not serving code.
  localparam instruction_t INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/program_store_ram.sv
// Purpose: DEPTH x instruction_t storage, one synchronous write port and one
// asynchronous read port.
// Ports:
//   clk              clock
//   we/waddr/wdata   write port, captured on the rising edge
//   raddr/rdata      combinational read port
module program_ram
  import isa::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instruction_t  wdata,
  input  logic [AW-1:0] raddr,
  output instruction_t  rdata
);

  instruction_t mem [DEPTH];

  // Contents are intentionally not reset; a new load overwrites them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_store.sv
// Purpose: on-chip instruction memory with a host-side valid/ready loader that
// holds the core in reset until a complete program is resident.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   program_counter   fetch address from control
//   instruction       fetched word, combinational from program_counter
//   load_valid/ready  host word handshake; load_data/load_last carry the word
//   core_rst          registered reset for control + multiprocessor
//   loaded            program resident, core running
//   load_fault        load aborted (overflow, or checksum mismatch)
// Build option: LOAD_CHECKSUM_EN makes the load_last word an XOR checksum of
// the stored words instead of a program word.
module program_store
  import isa::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  pc_t          program_counter,
  output instruction_t instruction,
  input  logic         load_valid,
  output logic         load_ready,
  input  instruction_t load_data,
  input  logic         load_last,
  output logic         core_rst,
  output logic         loaded,
  output logic         load_fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  loader_state_t state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          load_ready_q, load_ready_d;
  logic          core_rst_q, core_rst_d;
  logic          loaded_q, loaded_d;
  logic          load_fault_q, load_fault_d;
  logic          we;
  instruction_t  rdata;
  logic          pc_in_range;

`ifdef LOAD_CHECKSUM_EN
  instruction_t  csum_q, csum_d;
`endif

  // Next state, write strobe and registered-output targets.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    we        = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      LOAD: begin
        if (load_valid) begin
`ifdef LOAD_CHECKSUM_EN
          if (load_last) begin
            state_d = (load_data == csum_q) ? RUN : FAULT;
          end else begin
            we        = 1'b1;
            wr_addr_d = wr_addr_q + AW'(1);
            csum_d    = csum_q ^ load_data;
            if (wr_addr_q == LAST_ADDR) begin
              state_d = FAULT;
            end
          end
`else
          we        = 1'b1;
          wr_addr_d = wr_addr_q + AW'(1);
          // A last word landing in the final slot is a complete program, not an overflow.
          if (load_last) begin
            state_d = RUN;
          end else if (wr_addr_q == LAST_ADDR) begin
            state_d = FAULT;
          end
`endif
        end
      end
      RUN:     state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = LOAD;
    endcase

    // Outputs follow the state being entered, so core_rst drops on the RUN edge.
    load_ready_d = (state_d == LOAD);
    core_rst_d   = (state_d != RUN);
    loaded_d     = (state_d == RUN);
    load_fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      wr_addr_q    <= '0;
      load_ready_q <= 1'b1;
      core_rst_q   <= 1'b1;
      loaded_q     <= 1'b0;
      load_fault_q <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      load_ready_q <= load_ready_d;
      core_rst_q   <= core_rst_d;
      loaded_q     <= loaded_d;
      load_fault_q <= load_fault_d;
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  program_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (load_data),
    .raddr (program_counter[AW-1:0]),
    .rdata (rdata)
  );

  // Reads are gated to RUN, so they never observe a partially loaded program.
  assign pc_in_range = (32'(program_counter) < DEPTH);
  assign instruction = ((state_q == RUN) && pc_in_range) ? rdata : INSTR_NOP;

  assign load_ready = load_ready_q;
  assign core_rst   = core_rst_q;
  assign loaded     = loaded_q;
  assign load_fault = load_fault_q;

endmodule

// File: tb/tb_program_store.sv
module tb_program_store;
  import isa::*;

  localparam int unsigned DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  pc_t          program_counter = '0;
  instruction_t instruction;
  logic         load_valid = 1'b0;
  logic         load_ready;
  instruction_t load_data = '0;
  logic         load_last = 1'b0;
  logic         core_rst;
  logic         loaded;
  logic         load_fault;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_store #(.DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .program_counter (program_counter),
    .instruction     (instruction),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_last       (load_last),
    .core_rst        (core_rst),
    .loaded          (loaded),
    .load_fault      (load_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one word from a negedge; handshake completes at the following posedge.
  task automatic push(input string tag, input logic [31:0] data, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    check(tag, 32'(load_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input int unsigned pc, input logic [31:0] exp);
    program_counter = pc_t'(pc);
    #1;
    check(tag, instruction, exp);
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic crst,
                              input logic ld, input logic flt);
    check({tag, "_ready"},    32'(load_ready), 32'(rdy));
    check({tag, "_core_rst"}, 32'(core_rst),   32'(crst));
    check({tag, "_loaded"},   32'(loaded),     32'(ld));
    check({tag, "_fault"},    32'(load_fault), 32'(flt));
  endtask

  initial begin
    // T1: reset values, then a 3-word back-to-back load.
    do_reset();
    check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    fetch("reset_nop", 0, INSTR_NOP);
    push("t1_w0_ready", 32'h11, 1'b0);
    push("t1_w1_ready", 32'h22, 1'b0);
    push("t1_w2_ready", 32'h33, 1'b1);   // also the checksum 0x11^0x22 in checksum builds
    idle();
    check_status("t1_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("t1_pc1", 1, 32'h22);
    fetch("t1_pc0", 0, 32'h11);
`ifndef LOAD_CHECKSUM_EN
    fetch("t1_pc2", 2, 32'h33);
`endif

    // T4: out-of-range PC and host traffic while running.
    fetch("t4_pc_oob", DEPTH, INSTR_NOP);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'h99;
    load_last  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t4_ready_low", 32'(load_ready), 32'd0);
    end
    idle();
    fetch("t4_pc0_kept", 0, 32'h11);
    fetch("t4_pc1_kept", 1, 32'h22);
    check("t4_still_run", 32'(loaded), 32'd1);

    // T2: valid toggling every cycle; each word written exactly once.
    do_reset();
    fetch("t2_load_nop", 0, INSTR_NOP);
    for (int i = 0; i < 4; i++) begin
      push("t2_ready", 32'h40 + 32'(i), (i == 3));  // 0x43 is also 0x40^0x41^0x42
      idle();
      if (i < 3) check("t2_not_yet_run", 32'(loaded), 32'd0);
    end
    check_status("t2_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("t2_pc0", 0, 32'h40);
    fetch("t2_pc1", 1, 32'h41);
    fetch("t2_pc2", 2, 32'h42);
`ifndef LOAD_CHECKSUM_EN
    fetch("t2_pc3", 3, 32'h43);
`endif

    // T3: fill every slot without load_last -> overflow fault.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push("t3_ready", 32'h50 + 32'(i), 1'b0);
    end
    idle();
    check_status("t3_fault", 1'b0, 1'b1, 1'b0, 1'b1);
    fetch("t3_nop", 0, INSTR_NOP);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'h58;
    repeat (3) begin
      @(negedge clk);
      check("t3_9th_blocked", 32'(load_ready), 32'd0);
      check("t3_fault_sticky", 32'(load_fault), 32'd1);
    end
    idle();

    // T5: reset in the middle of a load restarts from address 0.
    do_reset();
    check("t5_fault_cleared", 32'(load_fault), 32'd0);
    push("t5_p0", 32'hC0, 1'b0);
    push("t5_p1", 32'hC1, 1'b0);
    do_reset();
    push("t5_w0", 32'hA0, 1'b0);
`ifdef LOAD_CHECKSUM_EN
    push("t5_w1", 32'hA0, 1'b1);   // matches only if csum restarted at 0
`else
    push("t5_w1", 32'hB0, 1'b1);
`endif
    idle();
    check_status("t5_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("t5_pc0", 0, 32'hA0);
`ifndef LOAD_CHECKSUM_EN
    fetch("t5_pc1", 1, 32'hB0);
`endif
    fetch("t5_pc2_old", 2, 32'h52);

    // T7: last word arriving in the final slot means RUN, not FAULT.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push("t7_ready", 32'h60 + 32'(i), 1'b0);
    end
    push("t7_last", 32'h67, 1'b1);  // 0x67 is also the XOR of 0x60..0x66
    idle();
    check_status("t7_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("t7_pc6", 6, 32'h66);
`ifdef LOAD_CHECKSUM_EN
    fetch("t7_pc7", 7, 32'h57);
`else
    fetch("t7_pc7", 7, 32'h67);
`endif

`ifdef LOAD_CHECKSUM_EN
    // T6: checksum accept and reject; the checksum word is never stored.
    do_reset();
    push("t6a_w0", 32'h0F, 1'b0);
    push("t6a_w1", 32'hF0, 1'b0);
    push("t6a_sum", 32'hFF, 1'b1);
    idle();
    check_status("t6a_run", 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("t6a_pc0", 0, 32'h0F);
    fetch("t6a_pc1", 1, 32'hF0);
    fetch("t6a_pc2", 2, 32'h62);
    do_reset();
    push("t6b_w0", 32'h0F, 1'b0);
    push("t6b_w1", 32'hF0, 1'b0);
    push("t6b_sum", 32'hFE, 1'b1);
    idle();
    check_status("t6b_fault", 1'b0, 1'b1, 1'b0, 1'b1);
    fetch("t6b_nop", 0, INSTR_NOP);
    check("t6b_mem2", u_dut.u_ram.mem[2], 32'h62);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
